// File: rtl/card_dealer.sv
// card_dealer: keypad-driven card flipper feeding the bell judge (cards, table count, turn, freeze).
// Optional per-player deck limit is compiled in when DEALER_DECK_LIMIT_EN is defined.
module card_dealer #(
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter logic [3:0]  KEY_FLIP_A = 4'b0001,
  parameter logic [3:0]  KEY_FLIP_B = 4'b0011,
  parameter logic [7:0]  DECK_SIZE  = 8'd28
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] keypad_in,
  input  logic       finish,
  output logic [1:0] c1,
  output logic [1:0] c2,
  output logic [2:0] n1,
  output logic [2:0] n2,
  output logic [7:0] count,
  output logic       turn,
  output logic       frozen,
  output logic       game_over
);

  localparam logic [3:0] KEY_BELL_A = 4'b0111;
  localparam logic [3:0] KEY_BELL_B = 4'b1001;

  typedef enum logic [1:0] {S_PLAY, S_HOLD, S_CLEAR} state_t;

  state_t      r_state, w_state_next;
  logic [15:0] r_lfsr, w_lfsr_next;
  logic [3:0]  r_key_q;
  logic [1:0]  r_c1, r_c2, w_c1_next, w_c2_next;
  logic [2:0]  r_n1, r_n2, w_n1_next, w_n2_next;
  logic [7:0]  r_count, w_count_next, w_count_inc;
  logic        r_turn, w_turn_next;
  logic        r_frozen, w_frozen_next;

  logic        w_key_new, w_bell, w_flip_a, w_flip_b, w_ok_a, w_ok_b;
  logic [1:0]  w_draw_c;
  logic [2:0]  w_draw_r, w_draw_n;

  assign w_lfsr_next = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  assign w_key_new   = (keypad_in != r_key_q);
  assign w_bell      = w_key_new && ((keypad_in == KEY_BELL_A) || (keypad_in == KEY_BELL_B));
  assign w_flip_a    = w_key_new && (keypad_in == KEY_FLIP_A) && !r_turn && w_ok_a;
  assign w_flip_b    = w_key_new && (keypad_in == KEY_FLIP_B) &&  r_turn && w_ok_b;

  // Draw from the pre-edge LFSR value; numbers 1..5, folding r=5..7 onto 1..3.
  assign w_draw_c    = r_lfsr[1:0];
  assign w_draw_r    = r_lfsr[4:2];
  assign w_draw_n    = (w_draw_r < 3'd5) ? (w_draw_r + 3'd1) : (w_draw_r - 3'd4);
  assign w_count_inc = (r_count == 8'hFF) ? r_count : (r_count + 8'd1);

`ifdef DEALER_DECK_LIMIT_EN
  logic [7:0] r_rem_a, r_rem_b, w_rem_a_next, w_rem_b_next;
  logic       r_game_over, w_game_over_next;

  assign w_ok_a    = !r_game_over && (r_rem_a != 8'd0);
  assign w_ok_b    = !r_game_over && (r_rem_b != 8'd0);
  assign game_over = r_game_over;
`else
  logic w_unused_deck;

  assign w_ok_a        = 1'b1;
  assign w_ok_b        = 1'b1;
  assign game_over     = 1'b0;
  assign w_unused_deck = ^DECK_SIZE;
`endif

  always_comb begin
    w_state_next  = r_state;
    w_c1_next     = r_c1;
    w_c2_next     = r_c2;
    w_n1_next     = r_n1;
    w_n2_next     = r_n2;
    w_count_next  = r_count;
    w_turn_next   = r_turn;
    w_frozen_next = r_frozen;
`ifdef DEALER_DECK_LIMIT_EN
    w_rem_a_next  = r_rem_a;
    w_rem_b_next  = r_rem_b;
`endif
    case (r_state)
      S_PLAY: begin
        // Finish beats a bell, and a bell beats a flip, on the same edge.
        if (finish) begin
          w_state_next = S_CLEAR;
        end else if (w_bell) begin
          w_state_next  = S_HOLD;
          w_frozen_next = 1'b1;
        end else if (w_flip_a) begin
          w_c1_next    = w_draw_c;
          w_n1_next    = w_draw_n;
          w_count_next = w_count_inc;
          w_turn_next  = 1'b1;
`ifdef DEALER_DECK_LIMIT_EN
          w_rem_a_next = r_rem_a - 8'd1;
`endif
        end else if (w_flip_b) begin
          w_c2_next    = w_draw_c;
          w_n2_next    = w_draw_n;
          w_count_next = w_count_inc;
          w_turn_next  = 1'b0;
`ifdef DEALER_DECK_LIMIT_EN
          w_rem_b_next = r_rem_b - 8'd1;
`endif
        end
      end
      S_HOLD: begin
        if (finish) w_state_next = S_CLEAR;
      end
      S_CLEAR: begin
        w_c1_next     = 2'd0;
        w_c2_next     = 2'd0;
        w_n1_next     = 3'd0;
        w_n2_next     = 3'd0;
        w_count_next  = 8'd0;
        w_frozen_next = 1'b0;
        if (!finish) w_state_next = S_PLAY;
      end
      default: w_state_next = S_PLAY;
    endcase
  end

`ifdef DEALER_DECK_LIMIT_EN
  assign w_game_over_next = r_game_over || (w_rem_a_next == 8'd0) || (w_rem_b_next == 8'd0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_PLAY;
      r_lfsr   <= LFSR_SEED;
      r_key_q  <= 4'b0000;
      r_c1     <= 2'd0;
      r_c2     <= 2'd0;
      r_n1     <= 3'd0;
      r_n2     <= 3'd0;
      r_count  <= 8'd0;
      r_turn   <= 1'b0;
      r_frozen <= 1'b0;
`ifdef DEALER_DECK_LIMIT_EN
      r_rem_a     <= DECK_SIZE;
      r_rem_b     <= DECK_SIZE;
      r_game_over <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_next;
      r_lfsr   <= w_lfsr_next;
      r_key_q  <= keypad_in;
      r_c1     <= w_c1_next;
      r_c2     <= w_c2_next;
      r_n1     <= w_n1_next;
      r_n2     <= w_n2_next;
      r_count  <= w_count_next;
      r_turn   <= w_turn_next;
      r_frozen <= w_frozen_next;
`ifdef DEALER_DECK_LIMIT_EN
      r_rem_a     <= w_rem_a_next;
      r_rem_b     <= w_rem_b_next;
      r_game_over <= w_game_over_next;
`endif
    end
  end

  assign c1     = r_c1;
  assign c2     = r_c2;
  assign n1     = r_n1;
  assign n2     = r_n2;
  assign count  = r_count;
  assign turn   = r_turn;
  assign frozen = r_frozen;

endmodule
